// File: rtl/riscv_pkg.sv
// Shared load/store definitions: FSM states, funct3 width codes, byte-enable
// patterns, the request payload struct and small decode helpers.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned F3_BITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // RISC-V load/store width and sign codes
    localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
    localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
    localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
    localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
    localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

    // Byte-enable patterns before lane shifting
    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic                 we;
        logic [F3_BITS-1:0]   funct3;
        logic [XLEN-1:0]      addr;
        logic [XLEN-1:0]      wdata;
    } lsu_req_t;

    // Reserved width codes, unsigned stores and misaligned halfword/word accesses
    function automatic logic lsu_illegal(input logic we,
                                         input logic [F3_BITS-1:0] f3,
                                         input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        if (f3[1:0] == 2'b01 && addr_lo[0])      bad = 1'b1;
        if (f3[1:0] == 2'b10 && addr_lo != 2'b00) bad = 1'b1;
        return bad;
    endfunction

    // Byte enables for a legal access
    function automatic logic [BE_W-1:0] lsu_be(input logic [F3_BITS-1:0] f3,
                                               input logic [1:0] addr_lo);
        logic [BE_W-1:0] be;
        case (f3[1:0])
            2'b00:   be = BE_BYTE << addr_lo;
            2'b01:   be = BE_HALF << addr_lo;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes
    function automatic logic [XLEN-1:0] lsu_wdata(input logic [F3_BITS-1:0] f3,
                                                  input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory signals of the load/store unit.
// master: CPU + memory side (drives requests and memory responses).
// slave:  the load/store unit itself.
interface load_store_unit_if;
    import riscv_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [F3_BITS-1:0]   req_funct3;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_wdata;

    logic                 resp_valid;
    logic [XLEN-1:0]      resp_rdata;
    logic                 resp_err;

    logic                 mem_req;
    logic                 mem_we;
    logic [BE_W-1:0]      mem_be;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN-1:0]      mem_wdata;
    logic                 mem_rvalid;
    logic [XLEN-1:0]      mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// load_extend: picks the addressed byte/halfword out of a memory read word and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports: rdata (memory word), funct3, addr_lo (byte offset), data_c (result).
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0]    rdata,
    input  logic [F3_BITS-1:0] funct3,
    input  logic [1:0]         addr_lo,
    output logic [XLEN-1:0]    data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension
    always_comb begin
        case (funct3)
            F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_c = {24'd0, byte_sel};
            F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_c = {16'd0, half_sel};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: accepts one CPU load/store at a time, issues a single
// data-memory access, and returns a one-cycle response with extended load data
// or an error (illegal request or memory timeout).
// Ports: clk, rst_n (async, active-low), bus (load_store_unit_if.slave) carrying
// the CPU request/response and the data-memory handshake.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Captured request attributes needed after acceptance
    logic                  we_q, we_d;
    logic [F3_BITS-1:0]    f3_q, f3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;

    // Registered outputs
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [BE_W-1:0]       mem_be_q, mem_be_d;
    logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    lsu_req_t              req_c;
    logic [XLEN-1:0]       ext_data_c;

    assign req_c = {bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata};

    load_extend u_load_extend (
        .rdata   (bus.mem_rdata),
        .funct3  (f3_q),
        .addr_lo (addr_lo_q),
        .data_c  (ext_data_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_lo_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_lo_q    <= addr_lo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_lo_d    = addr_lo_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d      = req_c.we;
                    f3_d      = req_c.funct3;
                    addr_lo_d = req_c.addr[1:0];
                    if (lsu_illegal(req_c.we, req_c.funct3, req_c.addr[1:0])) begin
                        // Rejected without touching memory
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_BUSY;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_c.we;
                        mem_be_d    = lsu_be(req_c.funct3, req_c.addr[1:0]);
                        mem_addr_d  = {req_c.addr[XLEN-1:2], 2'b00};
                        mem_wdata_d = lsu_wdata(req_c.funct3, req_c.wdata);
                    end
                end
            end

            ST_BUSY: begin
                mem_req_d = 1'b1;
                mem_we_d  = mem_we_q;
                mem_be_d  = mem_be_q;
                // An acknowledge in the last counted cycle beats the timeout
                if (bus.mem_rvalid) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : ext_data_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge; returns at the negedge after acceptance
    task automatic start_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0000) begin n_fail++; $display("FAIL reset_we_be: got %b/%b expected 0/0000", bus.mem_we, bus.mem_be); end
        n_tests++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
        n_tests++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp: got %b/%b/%h expected 0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
    endtask

    // LW with acknowledge in the first BUSY cycle: minimum latency
    task automatic test_lw();
        start_req(1'b0, 3'b010, 32'h0000_0010, 32'h0);
        n_tests++; if (bus.mem_req !== 1'b1 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL lw_busy: got req=%b ready=%b expected 1/0", bus.mem_req, bus.req_ready); end
        n_tests++; if (bus.mem_be !== 4'b1111 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_be: got be=%b we=%b expected 1111/0", bus.mem_be, bus.mem_we); end
        n_tests++; if (bus.mem_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL lw_addr: got %h expected 00000010", bus.mem_addr); end
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_early_resp: got %b expected 0", bus.resp_valid); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL lw_resp: got valid=%b err=%b expected 1/0", bus.resp_valid, bus.resp_err); end
        n_tests++; if (bus.resp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", bus.resp_rdata); end
        n_tests++; if (bus.mem_req !== 1'b0 || bus.mem_be !== 4'b0000 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL lw_resp_state: got req=%b be=%b ready=%b expected 0/0000/0", bus.mem_req, bus.mem_be, bus.req_ready); end
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_back_idle: got valid=%b ready=%b expected 0/1", bus.resp_valid, bus.req_ready); end
    endtask

    // Acknowledge after three BUSY cycles; request held stable meanwhile
    task automatic test_wait_states();
        start_req(1'b0, 3'b010, 32'h0000_0014, 32'h0);
        repeat (3) begin
            n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0014 || bus.mem_be !== 4'b1111) begin n_fail++; $display("FAIL wait_hold: got req=%b addr=%h be=%b expected 1/00000014/1111", bus.mem_req, bus.mem_addr, bus.mem_be); end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_resp: got valid=%b data=%h expected 1/12345678", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_load_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] rdata, input logic [3:0] exp_be, input logic [31:0] exp_data);
        start_req(1'b0, f3, addr, 32'h0);
        n_tests++; if (bus.mem_be !== exp_be || bus.mem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_be_addr: got %b/%h expected %b/%h", name, bus.mem_be, bus.mem_addr, exp_be, {addr[31:2], 2'b00}); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== exp_data) begin n_fail++; $display("FAIL %s_resp: got valid=%b err=%b data=%h expected 1/0/%h", name, bus.resp_valid, bus.resp_err, bus.resp_rdata, exp_data); end
        @(negedge clk);
    endtask

    task automatic test_store_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        start_req(1'b1, f3, addr, wdata);
        n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_be !== exp_be) begin n_fail++; $display("FAIL %s_we_be: got %b/%b expected 1/%b", name, bus.mem_we, bus.mem_be, exp_be); end
        n_tests++; if (bus.mem_wdata !== exp_wdata || bus.mem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_wdata_addr: got %h/%h expected %h/%h", name, bus.mem_wdata, bus.mem_addr, exp_wdata, {addr[31:2], 2'b00}); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL %s_resp: got valid=%b err=%b data=%h expected 1/0/00000000", name, bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        @(negedge clk);
        n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0000) begin n_fail++; $display("FAIL %s_idle_we_be: got %b/%b expected 0/0000", name, bus.mem_we, bus.mem_be); end
    endtask

    task automatic test_illegal();
        logic        we_t [6]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t [6]   = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b111, 3'b010};
        logic [31:0] addr_t [6] = '{32'h02, 32'h01, 32'h00, 32'h00, 32'h04, 32'h03};
        for (int i = 0; i < 6; i++) begin
            start_req(we_t[i], f3_t[i], addr_t[i], 32'h1234_5678);
            n_tests++; if (bus.mem_req !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL illegal_%0d: got req=%b valid=%b err=%b data=%h expected 0/1/1/00000000", i, bus.mem_req, bus.resp_valid, bus.resp_err, bus.resp_rdata); end
            @(negedge clk);
            n_tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL illegal_%0d_idle: got valid=%b ready=%b req=%b expected 0/1/0", i, bus.resp_valid, bus.req_ready, bus.mem_req); end
        end
    endtask

    task automatic test_timeout();
        int busy_cycles;
        logic got;
        busy_cycles = 0;
        got = 1'b0;
        start_req(1'b0, 3'b010, 32'h0000_0030, 32'h0);
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.resp_valid === 1'b1) got = 1'b1;
            else begin
                if (bus.mem_req === 1'b1) busy_cycles++;
                @(negedge clk);
            end
        end
        n_tests++; if (!got) begin n_fail++; $display("FAIL timeout_no_resp: got no resp_valid in 40 cycles expected resp_valid"); end
        n_tests++; if (busy_cycles != 16) begin n_fail++; $display("FAIL timeout_busy_len: got %0d expected 16", busy_cycles); end
        n_tests++; if (bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_resp: got err=%b data=%h req=%b expected 1/00000000/0", bus.resp_err, bus.resp_rdata, bus.mem_req); end
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got ready=%b valid=%b expected 1/0", bus.req_ready, bus.resp_valid); end
    endtask

    // Acknowledge in the 16th BUSY cycle beats the timeout
    task automatic test_rvalid_last();
        start_req(1'b0, 3'b010, 32'h0000_0034, 32'h0);
        repeat (15) @(negedge clk);
        n_tests++; if (bus.mem_req !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL last_busy: got req=%b valid=%b expected 1/0", bus.mem_req, bus.resp_valid); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55AA_55AA;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h55AA_55AA) begin n_fail++; $display("FAIL last_resp: got valid=%b err=%b data=%h expected 1/0/55aa55aa", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_stray_rvalid();
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hAAAA_AAAA;
        repeat (2) @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid: got valid=%b ready=%b req=%b expected 0/1/0", bus.resp_valid, bus.req_ready, bus.mem_req); end
    endtask

    // req_valid held high: second request must wait until IDLE after RESP
    task automatic test_back_to_back();
        start_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_0044;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0BAD_F00D || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got valid=%b data=%h ready=%b expected 1/0badf00d/0", bus.resp_valid, bus.resp_rdata, bus.req_ready); end
        @(negedge clk);
        n_tests++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_accept_in_resp: got req=%b ready=%b valid=%b expected 0/1/0", bus.mem_req, bus.req_ready, bus.resp_valid); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0044) begin n_fail++; $display("FAIL b2b_second_busy: got req=%b addr=%h expected 1/00000044", bus.mem_req, bus.mem_addr); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_0001;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h7777_0001) begin n_fail++; $display("FAIL b2b_second_resp: got valid=%b data=%h expected 1/77770001", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        start_req(1'b0, 3'b010, 32'h0000_0048, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_be !== 4'b0000) begin n_fail++; $display("FAIL midrst_async: got req=%b ready=%b be=%b expected 0/1/0000", bus.mem_req, bus.req_ready, bus.mem_be); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        @(negedge clk);
        n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resp: got %b expected 0", bus.resp_valid); end
        // Release and request together: accepted on the very next rising edge
        bus.mem_rvalid = 1'b0;
        rst_n          = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0050;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0050) begin n_fail++; $display("FAIL midrst_first_accept: got req=%b addr=%h expected 1/00000050", bus.mem_req, bus.mem_addr); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h2222_3333;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        n_tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h2222_3333) begin n_fail++; $display("FAIL midrst_resp: got valid=%b data=%h expected 1/22223333", bus.resp_valid, bus.resp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_lw();
        test_wait_states();
        test_load_case("lb",  3'b000, 32'h13, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80);
        test_load_case("lbu", 3'b100, 32'h13, 32'h8011_2233, 4'b1000, 32'h0000_0080);
        test_load_case("lb1", 3'b000, 32'h11, 32'h8011_2233, 4'b0010, 32'h0000_0022);
        test_load_case("lh",  3'b001, 32'h12, 32'h8011_2233, 4'b1100, 32'hFFFF_8011);
        test_load_case("lhu", 3'b101, 32'h12, 32'h8011_2233, 4'b1100, 32'h0000_8011);
        test_load_case("lh0", 3'b001, 32'h10, 32'h8011_F233, 4'b0011, 32'hFFFF_F233);
        test_store_case("sh", 3'b001, 32'h22, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        test_store_case("sb", 3'b000, 32'h21, 32'h1234_56EF, 4'b0010, 32'hEFEF_EFEF);
        test_store_case("sw", 3'b010, 32'h24, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        test_illegal();
        test_timeout();
        test_rvalid_last();
        test_stray_rvalid();
        test_back_to_back();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
